// File: rtl/instr_fetch_queue.sv
// Instruction fetch front end: PC ownership, req/ack memory fetch, circular prefetch queue.
// Optional macro IFQ_BYPASS_EN forwards a response straight to decode when the queue is empty.
module instr_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Reset,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr_code,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [AW-1:0] PTR_ZERO = {AW{1'b0}};
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_DROP = 2'd2;

    logic [1:0]    state_q, state_d;
    logic          mem_req_q, mem_req_d;
    // addr_q is what the bus sees; pc_q is the next fetch target and only differs in DROP
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   pc_q, pc_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [31:0]   code_q [DEPTH];
    logic [31:0]   pcs_q  [DEPTH];

    logic          fire_s, bypass_s, push_s, pop_s, head_valid_s;
    logic [31:0]   target_s;
    logic          out_valid_s;
    logic [31:0]   out_code_s, out_pc_s;

    assign target_s     = {redirect_pc[31:2], 2'b00};
    assign fire_s       = (state_q == ST_REQ) & mem_ack;
    assign head_valid_s = (count_q != CNT_ZERO);

`ifdef IFQ_BYPASS_EN
    assign bypass_s = fire_s & ~redirect & ~head_valid_s;
`else
    assign bypass_s = 1'b0;
`endif

    assign push_s = fire_s & ~redirect & ~(bypass_s & instr_ready);
    assign pop_s  = head_valid_s & instr_ready & ~redirect;

    // Queue pointer and occupancy update; a redirect flushes everything
    always_comb begin
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        if (redirect) begin
            wr_d    = PTR_ZERO;
            rd_d    = PTR_ZERO;
            count_d = CNT_ZERO;
        end else begin
            if (push_s) wr_d = wr_q + PTR_ONE;
            else        wr_d = wr_q;
            if (pop_s)  rd_d = rd_q + PTR_ONE;
            else        rd_d = rd_q;
            count_d = count_q + {{(CW-1){1'b0}}, push_s} - {{(CW-1){1'b0}}, pop_s};
        end
    end

    // Fetch FSM and address sequencing
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        pc_d    = pc_q;
        case (state_q)
            ST_IDLE: begin
                if (redirect) begin
                    addr_d = target_s;
                    pc_d   = target_s;
                end else if (count_d < DEPTH_C) begin
                    state_d = ST_REQ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (redirect) begin
                    pc_d = target_s;
                    if (mem_ack) begin
                        addr_d  = target_s;
                        state_d = ST_REQ;
                    end else begin
                        state_d = ST_DROP;
                    end
                end else if (mem_ack) begin
                    addr_d  = addr_q + 32'd4;
                    pc_d    = addr_q + 32'd4;
                    state_d = (count_d < DEPTH_C) ? ST_REQ : ST_IDLE;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_DROP: begin
                // The killed request still has to complete before the target is issued
                if (mem_ack) begin
                    addr_d  = redirect ? target_s : pc_q;
                    pc_d    = redirect ? target_s : pc_q;
                    state_d = (count_d < DEPTH_C) ? ST_REQ : ST_IDLE;
                end else if (redirect) begin
                    pc_d = target_s;
                end else begin
                    state_d = ST_DROP;
                end
            end
            default: begin
                state_d = ST_IDLE;
                addr_d  = pc_q;
            end
        endcase
        mem_req_d = (state_d != ST_IDLE);
    end

    // Control state registers
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= ST_IDLE;
            mem_req_q <= 1'b0;
            addr_q    <= RESET_PC;
            pc_q      <= RESET_PC;
            count_q   <= CNT_ZERO;
            wr_q      <= PTR_ZERO;
            rd_q      <= PTR_ZERO;
        end else begin
            state_q   <= state_d;
            mem_req_q <= mem_req_d;
            addr_q    <= addr_d;
            pc_q      <= pc_d;
            count_q   <= count_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
        end
    end

    // Queue storage
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                code_q[i] <= 32'h0000_0000;
                pcs_q[i]  <= 32'h0000_0000;
            end
        end else if (push_s) begin
            code_q[wr_q] <= mem_rdata;
            pcs_q[wr_q]  <= addr_q;
        end
    end

    // Head presentation; outputs are zero whenever nothing is valid
    always_comb begin
        out_valid_s = 1'b0;
        out_code_s  = 32'h0000_0000;
        out_pc_s    = 32'h0000_0000;
        if (head_valid_s) begin
            out_valid_s = 1'b1;
            out_code_s  = code_q[rd_q];
            out_pc_s    = pcs_q[rd_q];
        end else if (bypass_s) begin
            out_valid_s = 1'b1;
            out_code_s  = mem_rdata;
            out_pc_s    = addr_q;
        end else begin
            out_valid_s = 1'b0;
        end
    end

    assign mem_req     = mem_req_q;
    assign mem_addr    = addr_q;
    assign instr_valid = out_valid_s;
    assign instr_code  = out_code_s;
    assign instr_pc    = out_pc_s;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Self-checking bench for instr_fetch_queue: latency-programmable memory model feeding
// a scoreboard of expected PCs; decode-side consumption is checked against it.
module tb_instr_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        Clk;
    logic        Reset;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        instr_valid;
    logic [31:0] instr_code;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        redirect;
    logic [31:0] redirect_pc;

    int          n_checks;
    int          n_fail;
    int          n_consumed;
    int          lat;
    int          wait_cnt;
    bit          drop_next;
    logic [31:0] model_pc;
    logic [31:0] last_pc;
    logic [31:0] sb [$];

    instr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .instr_valid (instr_valid),
        .instr_code  (instr_code),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction

    // One clock: memory responds at negedge, consumption is checked just before the posedge.
    task automatic step();
        logic        ack;
        logic [31:0] exp_pc;
        @(negedge Clk);
        ack = 1'b0;
        if (mem_req === 1'b1) begin
            if (wait_cnt >= lat) begin
                ack = 1'b1;
                wait_cnt = 0;
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
        end
        mem_ack   = ack;
        mem_rdata = ack ? word_of(mem_addr) : 32'h0000_0000;
        if (ack) begin
            if (drop_next) begin
                drop_next = 1'b0;
            end else if (!redirect) begin
                n_checks++;
                if (mem_addr !== model_pc) begin
                    n_fail++;
                    $display("FAIL fetch_addr: mem_addr=%h required %h", mem_addr, model_pc);
                end
                sb.push_back(model_pc);
                model_pc = model_pc + 32'd4;
            end
        end
        if (redirect) begin
            sb.delete();
            model_pc = {redirect_pc[31:2], 2'b00};
            if (mem_req === 1'b1 && !ack) drop_next = 1'b1;
        end
        #4;
        if (instr_valid === 1'b1 && instr_ready && !redirect) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL out_unexpected: instr_pc=%h required no output", instr_pc);
            end else begin
                exp_pc = sb.pop_front();
                if (instr_pc !== exp_pc || instr_code !== word_of(exp_pc)) begin
                    n_fail++;
                    $display("FAIL out_word: pc=%h code=%h required pc=%h code=%h",
                             instr_pc, instr_code, exp_pc, word_of(exp_pc));
                end
                last_pc = instr_pc;
                n_consumed++;
            end
        end else if (instr_valid === 1'b0) begin
            n_checks++;
            if (instr_code !== 32'h0 || instr_pc !== 32'h0) begin
                n_fail++;
                $display("FAIL idle_zero: code=%h pc=%h required 0 0", instr_code, instr_pc);
            end
        end
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Reset     = 1'b1;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0000_0000;
        redirect  = 1'b0;
        sb.delete();
        model_pc  = RESET_PC;
        drop_next = 1'b0;
        wait_cnt  = 0;
        #2;
        n_checks++;
        if (mem_req !== 1'b0 || instr_valid !== 1'b0 || instr_code !== 32'h0 ||
            instr_pc !== 32'h0 || mem_addr !== RESET_PC) begin
            n_fail++;
            $display("FAIL reset_state: req=%b valid=%b code=%h pc=%h addr=%h required 0 0 0 0 %h",
                     mem_req, instr_valid, instr_code, instr_pc, mem_addr, RESET_PC);
        end
        @(posedge Clk);
        @(posedge Clk);
        #1;
        Reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (mem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL release_idle: mem_req=%b required 0", mem_req);
        end
        // A stray ack arriving while still IDLE must be ignored
        mem_ack   = 1'b1;
        mem_rdata = 32'hBAD0_BAD0;
        @(posedge Clk);
        #1;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0000_0000;
        n_checks++;
        if (mem_req !== 1'b1 || mem_addr !== RESET_PC || instr_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL first_req: req=%b addr=%h valid=%b required 1 %h 0",
                     mem_req, mem_addr, instr_valid, RESET_PC);
        end
    endtask

    task automatic test_stream();
        int c0;
        lat = 0;
        instr_ready = 1'b1;
        c0 = n_consumed;
        step();
`ifndef IFQ_BYPASS_EN
        n_checks++;
        if (instr_valid !== 1'b1 || instr_pc !== RESET_PC || instr_code !== word_of(RESET_PC)) begin
            n_fail++;
            $display("FAIL first_out: valid=%b pc=%h code=%h required 1 %h %h",
                     instr_valid, instr_pc, instr_code, RESET_PC, word_of(RESET_PC));
        end
        c0 = n_consumed;
`endif
        repeat (8) step();
        n_checks++;
        if (n_consumed - c0 != 8) begin
            n_fail++;
            $display("FAIL stream_rate: consumed=%0d required 8", n_consumed - c0);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        lat = 0;
        instr_ready = 1'b0;
        repeat (8) step();
        n_checks++;
        if (mem_req !== 1'b0 || mem_addr !== 32'h10 || instr_valid !== 1'b1 || instr_pc !== 32'h0) begin
            n_fail++;
            $display("FAIL full_stall: req=%b addr=%h valid=%b pc=%h required 0 00000010 1 00000000",
                     mem_req, mem_addr, instr_valid, instr_pc);
        end
        instr_ready = 1'b1;
        step();
        n_checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h10) begin
            n_fail++;
            $display("FAIL resume: req=%b addr=%h required 1 00000010", mem_req, mem_addr);
        end
        repeat (8) step();
        n_checks++;
        if (last_pc !== 32'h20) begin
            n_fail++;
            $display("FAIL drain_order: last_pc=%h required 00000020", last_pc);
        end
    endtask

    task automatic test_latency();
        int c0;
        do_reset();
        lat = 3;
        instr_ready = 1'b1;
        step();
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (mem_req !== 1'b1 || mem_addr !== 32'h0 || instr_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL lat_hold[%0d]: req=%b addr=%h valid=%b required 1 00000000 0",
                         i, mem_req, mem_addr, instr_valid);
            end
        end
        c0 = n_consumed;
        step();
        n_checks++;
        if (mem_addr !== 32'h4) begin
            n_fail++;
            $display("FAIL lat_advance: addr=%h required 00000004", mem_addr);
        end
`ifndef IFQ_BYPASS_EN
        n_checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || n_consumed != c0) begin
            n_fail++;
            $display("FAIL lat_out: valid=%b pc=%h consumed=%0d required 1 00000000 0",
                     instr_valid, instr_pc, n_consumed - c0);
        end
`endif
        repeat (8) step();
        n_checks++;
        if (mem_addr !== 32'hC) begin
            n_fail++;
            $display("FAIL lat_rate: addr=%h required 0000000c", mem_addr);
        end
    endtask

    task automatic test_redirect_pending();
        do_reset();
        lat = 3;
        instr_ready = 1'b1;
        repeat (9) step();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0100;
        step();
        redirect = 1'b0;
        n_checks++;
        if (instr_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 32'h8) begin
            n_fail++;
            $display("FAIL drop_state: valid=%b req=%b addr=%h required 0 1 00000008",
                     instr_valid, mem_req, mem_addr);
        end
        repeat (8) step();
        n_checks++;
        if (last_pc !== 32'h100 || mem_addr !== 32'h104) begin
            n_fail++;
            $display("FAIL redirect_target: last_pc=%h addr=%h required 00000100 00000104",
                     last_pc, mem_addr);
        end
    endtask

    task automatic test_redirect_ack();
        logic [31:0] exp_last;
        lat = 0;
        instr_ready = 1'b1;
        repeat (3) step();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0203;
        step();
        redirect = 1'b0;
        n_checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h200) begin
            n_fail++;
            $display("FAIL redirect_ack_addr: req=%b addr=%h required 1 00000200", mem_req, mem_addr);
        end
`ifndef IFQ_BYPASS_EN
        n_checks++;
        if (instr_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL redirect_flush: valid=%b required 0", instr_valid);
        end
        exp_last = 32'h200;
`else
        exp_last = 32'h204;
`endif
        repeat (2) step();
        n_checks++;
        if (last_pc !== exp_last) begin
            n_fail++;
            $display("FAIL redirect_ack_next: last_pc=%h required %h", last_pc, exp_last);
        end
    endtask

`ifdef IFQ_BYPASS_EN
    task automatic test_bypass();
        int c0;
        do_reset();
        lat = 3;
        instr_ready = 1'b1;
        repeat (4) step();
        c0 = n_consumed;
        step();
        n_checks++;
        if (n_consumed != c0 + 1 || last_pc !== 32'h0) begin
            n_fail++;
            $display("FAIL bypass_same_cycle: consumed=%0d last_pc=%h required 1 00000000",
                     n_consumed - c0, last_pc);
        end
        step();
        n_checks++;
        if (instr_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bypass_no_push: valid=%b required 0", instr_valid);
        end
    endtask
`endif

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        n_consumed  = 0;
        lat         = 0;
        wait_cnt    = 0;
        drop_next   = 1'b0;
        model_pc    = RESET_PC;
        last_pc     = 32'h0;
        Reset       = 1'b1;
        mem_ack     = 1'b0;
        mem_rdata   = 32'h0;
        instr_ready = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        #1;
        test_reset();
        test_stream();
        test_backpressure();
        test_latency();
        test_redirect_pending();
        test_redirect_ack();
`ifdef IFQ_BYPASS_EN
        test_bypass();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
